// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: pointer/flag controller for a single-clock FIFO built
// around an external memory with one cycle of read latency.
//
// Parameters
//   FIFO_DEPTH         word capacity of the memory (power of two, >= 2)
//   ADDR_WIDTH         log2(FIFO_DEPTH)
//   GREY_CODE          1: gray-coded addresses, 0: binary
//   ACK_ENA            1: wr_ack active, 0: wr_ack tied low
//   FWFT               1: first-word-fall-through, 0: standard read
//   PROG_FULL_THRESH   prog_full when data_count >= this
//   PROG_EMPTY_THRESH  prog_empty when data_count <= this
//
// Ports
//   clk, rstn                       clock, async active-low reset
//   wr_en / wr_addr / wr_mem_en     write request, memory write address/strobe
//   wr_ack / wr_overflow            previous-cycle write accepted / rejected
//   wr_full / prog_full             full and programmable-full flags
//   rd_en / rd_addr / rd_mem_en     read request (pop), memory read address/strobe
//   rd_valid / rd_empty             memory output valid / nothing to read
//   rd_underflow / prog_empty       previous-cycle read rejected, prog-empty flag
//   data_count                      words held (incl. the FWFT output word)
module fifo_sync_ctrl #(
  parameter int FIFO_DEPTH        = 256,
  parameter int ADDR_WIDTH        = 8,
  parameter int GREY_CODE         = 0,
  parameter int ACK_ENA           = 0,
  parameter int FWFT              = 0,
  parameter int PROG_FULL_THRESH  = FIFO_DEPTH - 2,
  parameter int PROG_EMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_mem_en,
  output logic                  wr_ack,
  output logic                  wr_full,
  output logic                  wr_overflow,
  output logic                  prog_full,
  input  logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_mem_en,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_underflow,
  output logic                  prog_empty,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PF_C    = PW'(PROG_FULL_THRESH);
  localparam logic [PW-1:0] PE_C    = PW'(PROG_EMPTY_THRESH);

  typedef enum logic {IDLE = 1'b0, READY = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q, mem_count;
  logic                  wr_ack_q, wr_ovf_q, rd_unf_q, rd_vld_q;
  logic                  wr_fire, rd_fire, mem_nz, out_ready;
  logic [ADDR_WIDTH-1:0] wa, ra;

  // Pointers carry a wrap bit, so the difference distinguishes full from empty.
  assign mem_count = wr_ptr_q - rd_ptr_q;
  assign mem_nz    = |mem_count;
  assign out_ready = (FWFT != 0) && (state_q == READY);

  // Full comes from registered pointers only: a same-cycle pop does not
  // make room for a write.
  assign wr_full = (mem_count == DEPTH_C);
  assign wr_fire = wr_en & ~wr_full;

  // Read side: standard mode pops on request; FWFT prefetches into the
  // output word whenever it is empty and refills it on each pop.
  always_comb begin
    state_d = state_q;
    rd_fire = 1'b0;
    if (FWFT != 0) begin
      case (state_q)
        IDLE: begin
          if (mem_nz) begin
            rd_fire = 1'b1;
            state_d = READY;
          end
        end
        READY: begin
          if (rd_en) begin
            if (mem_nz) rd_fire = 1'b1;
            else        state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      rd_fire = rd_en & mem_nz;
    end
  end

  assign rd_empty   = (FWFT != 0) ? ~out_ready : ~mem_nz;
  assign data_count = mem_count + {{ADDR_WIDTH{1'b0}}, out_ready};
  assign prog_full  = (data_count >= PF_C);
  assign prog_empty = (data_count <= PE_C);

  // Strobes are forced low while reset is held.
  assign wr_mem_en = wr_fire & rstn;
  assign rd_mem_en = rd_fire & rstn;

  assign wa      = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ra      = rd_ptr_q[ADDR_WIDTH-1:0];
  assign wr_addr = (GREY_CODE != 0) ? (wa ^ (wa >> 1)) : wa;
  assign rd_addr = (GREY_CODE != 0) ? (ra ^ (ra >> 1)) : ra;

  assign rd_valid     = (FWFT != 0) ? out_ready : rd_vld_q;
  assign wr_ack       = wr_ack_q;
  assign wr_overflow  = wr_ovf_q;
  assign rd_underflow = rd_unf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_ack_q <= 1'b0;
      wr_ovf_q <= 1'b0;
      rd_unf_q <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_fire};
      rd_ptr_q <= rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_fire};
      wr_ack_q <= (ACK_ENA != 0) & wr_fire;
      wr_ovf_q <= wr_en & wr_full;
      rd_unf_q <= rd_en & rd_empty;
      rd_vld_q <= (FWFT == 0) & rd_fire;
    end
  end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench: instance A is standard-read, binary addresses, ack on;
// instance B is FWFT with gray addresses. Depth 8, thresholds 6/2.
module tb_fifo_sync_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       a_wr, a_rd, b_wr, b_rd;
  logic [2:0] a_waddr, a_raddr, b_waddr, b_raddr;
  logic       a_wme, a_ack, a_full, a_ovf, a_pf, a_rme, a_vld, a_emp, a_unf, a_pe;
  logic       b_wme, b_ack, b_full, b_ovf, b_pf, b_rme, b_vld, b_emp, b_unf, b_pe;
  logic [3:0] a_dc, b_dc;

  int checks = 0;
  int passes = 0;
  int ew, er;

  always #5 clk = ~clk;

  fifo_sync_ctrl #(.FIFO_DEPTH(8), .ADDR_WIDTH(3), .GREY_CODE(0), .ACK_ENA(1),
                   .FWFT(0), .PROG_FULL_THRESH(6), .PROG_EMPTY_THRESH(2)) u_a (
    .clk(clk), .rstn(rstn), .wr_en(a_wr), .wr_addr(a_waddr), .wr_mem_en(a_wme),
    .wr_ack(a_ack), .wr_full(a_full), .wr_overflow(a_ovf), .prog_full(a_pf),
    .rd_en(a_rd), .rd_addr(a_raddr), .rd_mem_en(a_rme), .rd_valid(a_vld),
    .rd_empty(a_emp), .rd_underflow(a_unf), .prog_empty(a_pe), .data_count(a_dc));

  fifo_sync_ctrl #(.FIFO_DEPTH(8), .ADDR_WIDTH(3), .GREY_CODE(1), .ACK_ENA(0),
                   .FWFT(1), .PROG_FULL_THRESH(6), .PROG_EMPTY_THRESH(2)) u_b (
    .clk(clk), .rstn(rstn), .wr_en(b_wr), .wr_addr(b_waddr), .wr_mem_en(b_wme),
    .wr_ack(b_ack), .wr_full(b_full), .wr_overflow(b_ovf), .prog_full(b_pf),
    .rd_en(b_rd), .rd_addr(b_raddr), .rd_mem_en(b_rme), .rd_valid(b_vld),
    .rd_empty(b_emp), .rd_underflow(b_unf), .prog_empty(b_pe), .data_count(b_dc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    tick(); tick();

    // Reset state, with requests asserted to show strobes stay low.
    a_wr = 1'b1; b_rd = 1'b1;
    #1;
    chk("rst_wme", a_wme, 0);
    chk("rst_dc", a_dc, 0);
    chk("rst_full", a_full, 0);
    chk("rst_empty", a_emp, 1);
    chk("rst_pe", a_pe, 1);
    chk("rst_pf", a_pf, 0);
    chk("rst_waddr", a_waddr, 0);
    chk("rst_vld", a_vld, 0);
    chk("rst_b_empty", b_emp, 1);
    chk("rst_b_rme", b_rme, 0);
    a_wr = 1'b0; b_rd = 1'b0;
    tick();
    rstn = 1'b1;

    // Fill A to full; prog_full from 6, prog_empty up to 2.
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1;
      #1;
      chk($sformatf("fill%0d_wme", i), a_wme, 1);
      chk($sformatf("fill%0d_addr", i), a_waddr, i);
      chk($sformatf("fill%0d_dc", i), a_dc, i);
      chk($sformatf("fill%0d_pf", i), a_pf, (i >= 6));
      chk($sformatf("fill%0d_pe", i), a_pe, (i <= 2));
      tick();
    end
    #1;
    chk("full_flag", a_full, 1);
    chk("full_dc", a_dc, 8);
    chk("full_pf", a_pf, 1);
    chk("w9_wme", a_wme, 0);
    chk("w8_ack", a_ack, 1);
    tick();
    chk("w9_ovf", a_ovf, 1);
    chk("w9_noack", a_ack, 0);

    // Full with simultaneous read and write: read taken, write rejected.
    a_rd = 1'b1;
    #1;
    chk("fullrw_rme", a_rme, 1);
    chk("fullrw_wme", a_wme, 0);
    chk("fullrw_raddr", a_raddr, 0);
    tick();
    a_wr = 1'b0; a_rd = 1'b0;
    #1;
    chk("fullrw_dc", a_dc, 7);
    chk("fullrw_ovf", a_ovf, 1);
    chk("fullrw_vld", a_vld, 1);
    chk("fullrw_notfull", a_full, 0);

    // Reset, then write 3 and hold rd_en for 4 cycles.
    rstn = 1'b0;
    #1;
    chk("rst2_dc", a_dc, 0);
    tick();
    rstn = 1'b1;
    a_wr = 1'b1;
    tick(); tick(); tick();
    a_wr = 1'b0; a_rd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rd%0d_rme", k), a_rme, (k < 3));
      if (k < 3) chk($sformatf("rd%0d_addr", k), a_raddr, k);
      chk($sformatf("rd%0d_vld", k), a_vld, (k >= 1));
      chk($sformatf("rd%0d_unf", k), a_unf, 0);
      tick();
    end
    a_rd = 1'b0;
    #1;
    chk("rd4_unf", a_unf, 1);
    chk("rd4_vld", a_vld, 0);
    chk("rd4_empty", a_emp, 1);

    // Bring A to 4 words, then 20 cycles of concurrent traffic across wrap.
    a_wr = 1'b1;
    tick(); tick(); tick(); tick();
    a_rd = 1'b1;
    ew = 7; er = 3;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk($sformatf("cc%0d_dc", c), a_dc, 4);
      chk($sformatf("cc%0d_waddr", c), a_waddr, ew % 8);
      chk($sformatf("cc%0d_raddr", c), a_raddr, er % 8);
      chk($sformatf("cc%0d_both", c), {a_wme, a_rme}, 2'b11);
      tick();
      ew++; er++;
    end
    a_rd = 1'b0;
    tick();
    #1;
    chk("mid_dc5", a_dc, 5);

    // Reset mid-burst with wr_en still high.
    rstn = 1'b0;
    #1;
    chk("mid_rst_dc", a_dc, 0);
    chk("mid_rst_wme", a_wme, 0);
    chk("mid_rst_waddr", a_waddr, 0);
    chk("mid_rst_raddr", a_raddr, 0);
    chk("mid_rst_empty", a_emp, 1);
    chk("mid_rst_pe", a_pe, 1);
    chk("mid_rst_ack", a_ack, 0);
    tick();
    rstn = 1'b1;
    #1;
    chk("post_rst_wme", a_wme, 1);
    chk("post_rst_waddr", a_waddr, 0);
    tick();
    a_wr = 1'b0;
    #1;
    chk("post_rst_dc", a_dc, 1);

    // FWFT: single write falls through two cycles later.
    b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
    #1;
    chk("fw_c1_rme", b_rme, 1);
    chk("fw_c1_empty", b_emp, 1);
    chk("fw_c1_dc", b_dc, 1);
    tick();
    chk("fw_c2_vld", b_vld, 1);
    chk("fw_c2_empty", b_emp, 0);
    chk("fw_c2_dc", b_dc, 1);
    chk("fw_c2_rme", b_rme, 0);
    tick();
    chk("fw_hold_vld", b_vld, 1);
    chk("fw_hold_raddr", b_raddr, 1);
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    #1;
    chk("fw_pop_empty", b_emp, 1);
    chk("fw_pop_dc", b_dc, 0);
    chk("fw_pop_vld", b_vld, 0);
    chk("fw_pop_unf", b_unf, 0);

    // FWFT with gray addresses: pointers 1,2,3 -> 1,3,2.
    b_wr = 1'b1;
    #1; chk("g_w1", b_waddr, 1); tick();
    chk("g_w2", b_waddr, 3); tick();
    chk("g_w3", b_waddr, 2); tick();
    b_wr = 1'b0;
    #1;
    chk("g_dc3", b_dc, 3);
    chk("g_raddr2", b_raddr, 3);
    chk("g_ack_tied", b_ack, 0);
    b_rd = 1'b1;
    tick();
    chk("g_dc2", b_dc, 2);
    chk("g_raddr3", b_raddr, 2);
    tick();
    chk("g_dc1", b_dc, 1);
    chk("g_last_vld", b_vld, 1);
    tick();
    b_rd = 1'b0;
    #1;
    chk("g_dc0", b_dc, 0);
    chk("g_empty", b_emp, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
